// File: rtl/errmon_pkg.sv
// Shared types, constants and the saturating-add helper for the locked-adder error monitor.
package errmon_pkg;

    typedef logic [1:0] errmon_state_e;

    localparam errmon_state_e IDLE   = 2'd0;
    localparam errmon_state_e RUN    = 2'd1;
    localparam errmon_state_e FLUSH  = 2'd2;
    localparam errmon_state_e REPORT = 2'd3;

    localparam int unsigned FLUSH_CYCLES = 2;

    // Add inc to acc and clamp at the all-ones value of a w-bit counter (w <= 63).
    function automatic logic [63:0] sat_add(input logic [63:0] acc, input logic [63:0] inc,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        lim = (65'd1 << w) - 65'd1;
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum > lim) begin
            sum = lim;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/errmon_popcount.sv
// Combinational population count of an N-bit vector.
module errmon_popcount #(
    parameter int unsigned N = 17
) (
    input  logic [N-1:0]             vec,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(N + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/locked_adder_error_monitor.sv
// Scores a key-locked adder against the golden sum and reports per-trial error statistics.
// Optional max |error| tracking is enabled with macro ERRMON_MAX_ABS_ERR_EN.
module locked_adder_error_monitor
    import errmon_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned KEY_W = 32,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned HD_W  = CNT_W + 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   result_i,
    input  logic             last_i,
    output logic             rpt_valid_o,
    input  logic             rpt_ready_i,
    output logic [KEY_W-1:0] rpt_key_o,
    output logic [CNT_W-1:0] rpt_vec_cnt_o,
    output logic [CNT_W-1:0] rpt_err_cnt_o,
    output logic [HD_W-1:0]  rpt_hd_sum_o,
    output logic [WIDTH:0]   rpt_max_err_o,
    output logic             busy_o
);

    localparam int unsigned RW  = WIDTH + 1;
    localparam int unsigned PCW = $clog2(RW + 1);
    localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    errmon_state_e  state, next_state;
    logic [FCW-1:0] flush_cnt, flush_cnt_nxt;
    logic           load_rpt_c;
    logic           accept_c;
    logic           start_acc_c;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [RW-1:0]    s1_res;
    logic [RW-1:0]    golden_c, diff_c;
    logic [PCW-1:0]   pc_c;
    logic             s2_valid, s2_err;
    logic [PCW-1:0]   s2_hd;

    logic [KEY_W-1:0] key_q;
    logic [CNT_W-1:0] vec_cnt, err_cnt;
    logic [HD_W-1:0]  hd_sum;

    assign accept_c    = in_valid_i && in_ready_o;
    assign start_acc_c = start_i && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= next_state;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Next state; the report is loaded once on the first REPORT cycle and then held.
    always_comb begin
        next_state    = state;
        flush_cnt_nxt = flush_cnt;
        load_rpt_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) next_state = RUN;
            end
            RUN: begin
                if (accept_c && last_i) begin
                    next_state    = FLUSH;
                    flush_cnt_nxt = '0;
                end
            end
            FLUSH: begin
                if (flush_cnt == FCW'(FLUSH_CYCLES - 1)) next_state = REPORT;
                else flush_cnt_nxt = flush_cnt + FCW'(1);
            end
            REPORT: begin
                if (!rpt_valid_o) load_rpt_c = 1'b1;
                else if (rpt_ready_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_o  <= 1'b0;
            busy_o      <= 1'b0;
            rpt_valid_o <= 1'b0;
        end else begin
            in_ready_o <= (next_state == RUN);
            busy_o     <= (next_state != IDLE);
            if (load_rpt_c) rpt_valid_o <= 1'b1;
            else if (rpt_valid_o && rpt_ready_i) rpt_valid_o <= 1'b0;
        end
    end

    // Stage 1: capture the accepted triple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_res   <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_a   <= add1_i;
                s1_b   <= add2_i;
                s1_res <= result_i;
            end
        end
    end

    assign golden_c = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff_c   = golden_c ^ s1_res;

    errmon_popcount #(.N(RW)) u_popcount (
        .vec   (diff_c),
        .count (pc_c)
    );

    // Stage 2: per-triple error flag and Hamming distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_hd    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_err   <= |diff_c;
            s2_hd    <= pc_c;
        end
    end

    // Trial accumulators; vectors are counted at acceptance, errors after stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            vec_cnt <= '0;
            err_cnt <= '0;
            hd_sum  <= '0;
        end else if (start_acc_c) begin
            key_q   <= key_i;
            vec_cnt <= '0;
            err_cnt <= '0;
            hd_sum  <= '0;
        end else begin
            if (accept_c) vec_cnt <= CNT_W'(sat_add(64'(vec_cnt), 64'd1, CNT_W));
            if (s2_valid) begin
                err_cnt <= CNT_W'(sat_add(64'(err_cnt), 64'(s2_err), CNT_W));
                hd_sum  <= HD_W'(sat_add(64'(hd_sum), 64'(s2_hd), HD_W));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_key_o     <= '0;
            rpt_vec_cnt_o <= '0;
            rpt_err_cnt_o <= '0;
            rpt_hd_sum_o  <= '0;
        end else if (load_rpt_c) begin
            rpt_key_o     <= key_q;
            rpt_vec_cnt_o <= vec_cnt;
            rpt_err_cnt_o <= err_cnt;
            rpt_hd_sum_o  <= hd_sum;
        end
    end

`ifdef ERRMON_MAX_ABS_ERR_EN
    logic [RW:0]   sdiff_c;
    logic [RW-1:0] abs_c;
    logic [RW-1:0] s2_abs;
    logic [RW-1:0] max_err;

    assign sdiff_c = {1'b0, golden_c} - {1'b0, s1_res};
    assign abs_c   = sdiff_c[RW] ? RW'(-sdiff_c) : RW'(sdiff_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_abs        <= '0;
            max_err       <= '0;
            rpt_max_err_o <= '0;
        end else begin
            s2_abs <= abs_c;
            if (start_acc_c) max_err <= '0;
            else if (s2_valid && (s2_abs > max_err)) max_err <= s2_abs;
            if (load_rpt_c) rpt_max_err_o <= max_err;
        end
    end
`else
    assign rpt_max_err_o = '0;
`endif

endmodule

// File: tb/tb_locked_adder_error_monitor.sv
// Directed bench for locked_adder_error_monitor; a second instance with CNT_W=4 checks saturation.
module tb_locked_adder_error_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [31:0] key_i;
    logic        in_valid_i;
    logic [15:0] add1_i, add2_i;
    logic [16:0] result_i;
    logic        last_i;
    logic        rpt_ready_i;

    logic        in_ready_o, rpt_valid_o, busy_o;
    logic [31:0] rpt_key_o;
    logic [15:0] rpt_vec_cnt_o, rpt_err_cnt_o;
    logic [20:0] rpt_hd_sum_o;
    logic [16:0] rpt_max_err_o;

    logic        s_in_ready, s_rpt_valid, s_busy;
    logic [31:0] s_rpt_key;
    logic [3:0]  s_vec, s_err;
    logic [8:0]  s_hd;
    logic [16:0] s_max;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    locked_adder_error_monitor #(.WIDTH(16), .KEY_W(32), .CNT_W(16), .HD_W(21)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .add1_i(add1_i), .add2_i(add2_i), .result_i(result_i), .last_i(last_i),
        .rpt_valid_o(rpt_valid_o), .rpt_ready_i(rpt_ready_i), .rpt_key_o(rpt_key_o),
        .rpt_vec_cnt_o(rpt_vec_cnt_o), .rpt_err_cnt_o(rpt_err_cnt_o),
        .rpt_hd_sum_o(rpt_hd_sum_o), .rpt_max_err_o(rpt_max_err_o), .busy_o(busy_o)
    );

    locked_adder_error_monitor #(.WIDTH(16), .KEY_W(32), .CNT_W(4), .HD_W(9)) u_sat (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i),
        .in_valid_i(in_valid_i), .in_ready_o(s_in_ready),
        .add1_i(add1_i), .add2_i(add2_i), .result_i(result_i), .last_i(last_i),
        .rpt_valid_o(s_rpt_valid), .rpt_ready_i(rpt_ready_i), .rpt_key_o(s_rpt_key),
        .rpt_vec_cnt_o(s_vec), .rpt_err_cnt_o(s_err),
        .rpt_hd_sum_o(s_hd), .rpt_max_err_o(s_max), .busy_o(s_busy)
    );

    task automatic do_start(input logic [31:0] k);
        @(negedge clk);
        start_i = 1'b1;
        key_i   = k;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] r,
                        input logic l);
        in_valid_i = 1'b1;
        add1_i     = a;
        add2_i     = b;
        result_i   = r;
        last_i     = l;
        @(negedge clk);
        in_valid_i = 1'b0;
        last_i     = 1'b0;
    endtask

    // Counts negedges from the one following the last acceptance until rpt_valid_o, bounded.
    task automatic wait_rpt(output int cycles);
        cycles = 0;
        while (!rpt_valid_o && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic ack();
        rpt_ready_i = 1'b1;
        @(negedge clk);
        rpt_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; key_i = '0; in_valid_i = 1'b0;
        add1_i = '0; add2_i = '0; result_i = '0; last_i = 1'b0; rpt_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rpt_valid_o, in_ready_o, busy_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {rpt_valid_o, in_ready_o, busy_o});
        end
        n_checks++;
        if ({rpt_key_o, rpt_vec_cnt_o, rpt_err_cnt_o, rpt_hd_sum_o, rpt_max_err_o} !== '0) begin
            n_fail++; $display("FAIL reset_rpt: got %0h expected 0", {rpt_key_o, rpt_vec_cnt_o});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        do_start(32'h00B89EB1);
        n_checks++;
        if (in_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL t1_run: got ready=%b busy=%b expected 1 1", in_ready_o, busy_o);
        end
        send(16'h0001, 16'h0002, 17'h00003, 1'b0);
        send(16'h1234, 16'h4321, 17'h05555, 1'b0);
        send(16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b0);
        send(16'h8000, 16'h8000, 17'h10000, 1'b1);
        n_checks++;
        if (in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL t1_ready_drop: got %b expected 0", in_ready_o);
        end
        wait_rpt(lat);
        n_checks++;
        if (lat != 3) begin n_fail++; $display("FAIL t1_latency: got %0d expected 3", lat); end
        n_checks++;
        if (rpt_key_o !== 32'h00B89EB1) begin
            n_fail++; $display("FAIL t1_key: got %0h expected 00b89eb1", rpt_key_o);
        end
        n_checks++;
        if (rpt_vec_cnt_o !== 16'd4) begin n_fail++; $display("FAIL t1_vec: got %0d expected 4", rpt_vec_cnt_o); end
        n_checks++;
        if (rpt_err_cnt_o !== 16'd0 || rpt_hd_sum_o !== 21'd0 || rpt_max_err_o !== 17'd0) begin
            n_fail++; $display("FAIL t1_err: got err=%0d hd=%0d max=%0h expected 0 0 0",
                               rpt_err_cnt_o, rpt_hd_sum_o, rpt_max_err_o);
        end
        ack();
    endtask

    task automatic test_bit_errors();
        logic [16:0] exp_max;
`ifdef ERRMON_MAX_ABS_ERR_EN
        exp_max = 17'd1;
`else
        exp_max = 17'd0;
`endif
        do_start(32'h0000_0002);
        send(16'd10,  16'd20, 17'd31,  1'b0);
        send(16'd5,   16'd5,  17'd10,  1'b0);
        send(16'd100, 16'd1,  17'd100, 1'b0);
        send(16'd7,   16'd8,  17'd15,  1'b0);
        send(16'd0,   16'd0,  17'd1,   1'b1);
        wait_rpt(lat);
        n_checks++;
        if (lat != 3) begin n_fail++; $display("FAIL t2_latency: got %0d expected 3", lat); end
        n_checks++;
        if (rpt_vec_cnt_o !== 16'd5) begin n_fail++; $display("FAIL t2_vec: got %0d expected 5", rpt_vec_cnt_o); end
        n_checks++;
        if (rpt_err_cnt_o !== 16'd3) begin n_fail++; $display("FAIL t2_err: got %0d expected 3", rpt_err_cnt_o); end
        n_checks++;
        if (rpt_hd_sum_o !== 21'd3) begin n_fail++; $display("FAIL t2_hd: got %0d expected 3", rpt_hd_sum_o); end
        n_checks++;
        if (rpt_max_err_o !== exp_max) begin
            n_fail++; $display("FAIL t2_max: got %0h expected %0h", rpt_max_err_o, exp_max);
        end
        ack();
    endtask

    task automatic test_carry();
        logic [16:0] exp_max;
`ifdef ERRMON_MAX_ABS_ERR_EN
        exp_max = 17'h10000;
`else
        exp_max = 17'd0;
`endif
        do_start(32'h0000_0003);
        send(16'hFFFF, 16'h0001, 17'h00000, 1'b1);
        wait_rpt(lat);
        n_checks++;
        if (rpt_vec_cnt_o !== 16'd1 || rpt_err_cnt_o !== 16'd1 || rpt_hd_sum_o !== 21'd1) begin
            n_fail++; $display("FAIL t3_counts: got vec=%0d err=%0d hd=%0d expected 1 1 1",
                               rpt_vec_cnt_o, rpt_err_cnt_o, rpt_hd_sum_o);
        end
        n_checks++;
        if (rpt_max_err_o !== exp_max) begin
            n_fail++; $display("FAIL t3_max: got %0h expected %0h", rpt_max_err_o, exp_max);
        end
        ack();
    endtask

    task automatic test_backpressure();
        do_start(32'hCAFE0004);
        send(16'd3, 16'd4, 17'd7, 1'b1);
        wait_rpt(lat);
        for (int i = 0; i < 5; i++) begin
            start_i = (i == 1);
            key_i   = 32'h12345678;
            @(negedge clk);
            start_i = 1'b0;
            n_checks++;
            if (rpt_valid_o !== 1'b1 || rpt_key_o !== 32'hCAFE0004 || rpt_vec_cnt_o !== 16'd1
                || in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                n_fail++; $display("FAIL t4_hold%0d: got v=%b key=%0h vec=%0d rdy=%b busy=%b expected 1 cafe0004 1 0 1",
                                   i, rpt_valid_o, rpt_key_o, rpt_vec_cnt_o, in_ready_o, busy_o);
            end
        end
        ack();
        n_checks++;
        if (rpt_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL t4_idle: got v=%b busy=%b expected 0 0", rpt_valid_o, busy_o);
        end
        n_checks++;
        if (rpt_key_o !== 32'hCAFE0004 || rpt_vec_cnt_o !== 16'd1) begin
            n_fail++; $display("FAIL t4_keep: got key=%0h vec=%0d expected cafe0004 1", rpt_key_o, rpt_vec_cnt_o);
        end
    endtask

    task automatic test_mid_reset();
        do_start(32'h0000_0005);
        send(16'd1, 16'd1, 17'd2, 1'b0);
        send(16'd2, 16'd2, 17'd4, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rpt_valid_o, in_ready_o, busy_o} !== 3'b000) begin
            n_fail++; $display("FAIL t5_ctrl: got %b expected 000", {rpt_valid_o, in_ready_o, busy_o});
        end
        n_checks++;
        if (rpt_key_o !== '0 || rpt_vec_cnt_o !== '0) begin
            n_fail++; $display("FAIL t5_rpt: got key=%0h vec=%0d expected 0 0", rpt_key_o, rpt_vec_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start(32'h0000_0055);
        send(16'd9,  16'd1,  17'd10, 1'b0);
        send(16'd20, 16'd22, 17'd42, 1'b0);
        send(16'd30, 16'd3,  17'd33, 1'b1);
        wait_rpt(lat);
        n_checks++;
        if (lat != 3 || rpt_vec_cnt_o !== 16'd3 || rpt_err_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL t5_after: got lat=%0d vec=%0d err=%0d expected 3 3 0",
                               lat, rpt_vec_cnt_o, rpt_err_cnt_o);
        end
        ack();
    endtask

    task automatic test_saturation();
        logic [16:0] s;
        do_start(32'h0000_0006);
        for (int i = 0; i < 20; i++) begin
            s = 17'(2 * i) ^ 17'h00001;
            send(16'(i), 16'(i), s, (i == 19));
        end
        wait_rpt(lat);
        n_checks++;
        if (rpt_vec_cnt_o !== 16'd20 || rpt_err_cnt_o !== 16'd20 || rpt_hd_sum_o !== 21'd20) begin
            n_fail++; $display("FAIL t6_wide: got vec=%0d err=%0d hd=%0d expected 20 20 20",
                               rpt_vec_cnt_o, rpt_err_cnt_o, rpt_hd_sum_o);
        end
        n_checks++;
        if (s_rpt_valid !== 1'b1 || s_vec !== 4'd15 || s_err !== 4'd15) begin
            n_fail++; $display("FAIL t6_sat: got v=%b vec=%0d err=%0d expected 1 15 15", s_rpt_valid, s_vec, s_err);
        end
        n_checks++;
        if (s_hd !== 9'd20) begin n_fail++; $display("FAIL t6_sat_hd: got %0d expected 20", s_hd); end
        ack();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bit_errors();
        test_carry();
        test_backpressure();
        test_mid_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
